// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory responder.
// Holds the FSM state enumeration, bus widths and the captured-request
// payload struct, plus a helper that expands byte-lane enables to a bit mask.
package dmem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned MASK_W = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Request fields latched at accept time (address index kept separately,
  // its width depends on DEPTH).
  typedef struct packed {
    logic              we;
    logic [MASK_W-1:0] mask;
    logic [WORD_W-1:0] wdata;
  } dmem_cap_t;

  // Byte-lane enables -> per-bit mask (lane i covers bits [8i+7:8i]).
  function automatic logic [WORD_W-1:0] lane_mask(input logic [MASK_W-1:0] m);
    return {{BYTE_W{m[3]}}, {BYTE_W{m[2]}}, {BYTE_W{m[1]}}, {BYTE_W{m[0]}}};
  endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Word-addressed storage split into byte lanes.
// Synchronous per-lane write, combinational read. Contents are never reset.
// Ports:
//   clk      clock
//   we_i     write enable (commits on rising edge)
//   be_i     byte-lane enables for the write
//   waddr_i  write word index
//   wdata_i  write data, lane-aligned
//   raddr_i  read word index
//   rdata_o  read data (combinational)
module dmem_byte_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [MASK_W-1:0] be_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  // One independent array per lane so each lane has a single writer.
  for (genvar b = 0; b < MASK_W; b++) begin : g_lane
    logic [BYTE_W-1:0] lane_q [DEPTH];

    always_ff @(posedge clk) begin
      if (we_i && be_i[b]) begin
        lane_q[waddr_i] <= wdata_i[b*BYTE_W +: BYTE_W];
      end
    end

    assign rdata_o[b*BYTE_W +: BYTE_W] = lane_q[raddr_i];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: accepts one load/store at a time from the core,
// waits LATENCY cycles, then pulses valid for one cycle. Stores commit at
// the edge that ends the response cycle; loads return enabled lanes with
// disabled lanes zeroed, and load_data holds until the next load response.
// Optional macro DMEM_RANGE_ERR_EN adds output err, flagging addresses with
// bits set above the storage index; such accesses are suppressed.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   request     start a transaction (sampled only in IDLE)
//   we_re       1 = store, 0 = load
//   mask        byte-lane enables
//   address     byte address (bits [1:0] ignored)
//   store_data  store data, lane-aligned
//   load_data   load data, lane-aligned
//   err         out-of-range flag (only with DMEM_RANGE_ERR_EN)
//   valid       one-cycle completion pulse
//   busy        transaction in progress
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              request,
  input  logic              we_re,
  input  logic [MASK_W-1:0] mask,
  input  logic [WORD_W-1:0] address,
  input  logic [WORD_W-1:0] store_data,
  output logic [WORD_W-1:0] load_data,
`ifdef DMEM_RANGE_ERR_EN
  output logic              err,
`endif
  output logic              valid,
  output logic              busy
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  dmem_cap_t         cap_q, cap_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic [WORD_W-1:0] load_q, load_d;
  logic [WORD_W-1:0] rdata_c;
  logic              wr_en_c;

`ifdef DMEM_RANGE_ERR_EN
  logic oor_q, oor_d;
  logic err_q, err_d;
  logic unused_c;
  assign unused_c = ^address[1:0];
`else
  logic unused_c;
  assign unused_c = ^{address[WORD_W-1:AW+2], address[1:0]};
`endif

  // Next-state, capture and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    idx_d   = idx_q;
`ifdef DMEM_RANGE_ERR_EN
    oor_d   = oor_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (request) begin
          cap_d = '{we: we_re, mask: mask, wdata: store_data};
          idx_d = address[AW+1:2];
`ifdef DMEM_RANGE_ERR_EN
          oor_d = |address[WORD_W-1:AW+2];
`endif
          if (LATENCY == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    valid_d = (state_d == S_RESP);
    busy_d  = (state_d != S_IDLE);
`ifdef DMEM_RANGE_ERR_EN
    err_d   = valid_d && oor_d;
`endif
  end

  // Load data is latched on entry to RESP; idx_d already points at the
  // transaction being answered (including the LATENCY=0 direct path).
  always_comb begin
    load_d = load_q;
    if (valid_d && !cap_d.we) begin
      load_d = rdata_c & lane_mask(cap_d.mask);
`ifdef DMEM_RANGE_ERR_EN
      if (oor_d) begin
        load_d = '0;
      end
`endif
    end
  end

  // Store commits at the edge leaving RESP, unless reset aborts it.
`ifdef DMEM_RANGE_ERR_EN
  assign wr_en_c = (state_q == S_RESP) && cap_q.we && !rst && !oor_q;
`else
  assign wr_en_c = (state_q == S_RESP) && cap_q.we && !rst;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      load_q  <= '0;
`ifdef DMEM_RANGE_ERR_EN
      oor_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      load_q  <= load_d;
`ifdef DMEM_RANGE_ERR_EN
      oor_q   <= oor_d;
      err_q   <= err_d;
`endif
    end
  end

  dmem_byte_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .we_i    (wr_en_c),
    .be_i    (cap_q.mask),
    .waddr_i (idx_q),
    .wdata_i (cap_q.wdata),
    .raddr_i (idx_d),
    .rdata_o (rdata_c)
  );

  assign load_data = load_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
`ifdef DMEM_RANGE_ERR_EN
  assign err       = err_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (LATENCY=1 and LATENCY=0)
// driven with directed and random transactions. A per-cycle monitor keeps a
// transaction-level model (one outstanding request, memory as a word array)
// and checks valid/busy/load_data/err against it.
module tb_data_mem_responder;
  import dmem_pkg::*;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int          N     = 2;

  function automatic int unsigned lat_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s   [N];
  logic        req_s   [N];
  logic        we_s    [N];
  logic [3:0]  mask_s  [N];
  logic [31:0] addr_s  [N];
  logic [31:0] wdata_s [N];
  logic [31:0] load_s  [N];
  logic        valid_s [N];
  logic        busy_s  [N];
`ifdef DMEM_RANGE_ERR_EN
  logic        err_s   [N];
`endif

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst_s[0]), .request(req_s[0]), .we_re(we_s[0]),
    .mask(mask_s[0]), .address(addr_s[0]), .store_data(wdata_s[0]),
    .load_data(load_s[0]),
`ifdef DMEM_RANGE_ERR_EN
    .err(err_s[0]),
`endif
    .valid(valid_s[0]), .busy(busy_s[0])
  );

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_dut_l0 (
    .clk(clk), .rst(rst_s[1]), .request(req_s[1]), .we_re(we_s[1]),
    .mask(mask_s[1]), .address(addr_s[1]), .store_data(wdata_s[1]),
    .load_data(load_s[1]),
`ifdef DMEM_RANGE_ERR_EN
    .err(err_s[1]),
`endif
    .valid(valid_s[1]), .busy(busy_s[1])
  );

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    int unsigned due;
    logic        we;
    logic [3:0]  mask;
    int unsigned word;
    logic        oor;
    logic [31:0] wdata;
  } txn_t;

  txn_t        sb_q    [N][$];
  logic [31:0] ref_mem [N][DEPTH];
  logic [31:0] last_rd [N];
  bit          armed   [N];
  bit          end_chk = 1'b0;
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] bytes_of(input logic [3:0] m);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < 4; i++) if (m[i]) r = r | (32'hFF << (8 * i));
    return r;
  endfunction

  function automatic void chk(input int d, input string name,
                              input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, d, cyc, got, exp);
    end
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < N; d++) begin
      bit          idle;
      bit          due;
      bit          exp_err;
      txn_t        t;
      logic [31:0] m;
      idle    = (sb_q[d].size() == 0);
      due     = !idle && (sb_q[d][0].due == cyc);
      exp_err = 1'b0;
      if (armed[d]) begin
        chk(d, "busy", 32'(busy_s[d]), 32'(!idle));
        chk(d, "valid", 32'(valid_s[d]), 32'(due));
        if (due) begin
          t = sb_q[d].pop_front();
          m = bytes_of(t.mask);
          exp_err = t.oor;
          if (!t.we) last_rd[d] = t.oor ? 32'h0 : (ref_mem[d][t.word] & m);
          else if (!t.oor) ref_mem[d][t.word] = (ref_mem[d][t.word] & ~m) | (t.wdata & m);
        end
        chk(d, "load_data", load_s[d], last_rd[d]);
`ifdef DMEM_RANGE_ERR_EN
        chk(d, "err", 32'(err_s[d]), 32'(exp_err));
`endif
        if (end_chk) chk(d, "drain", 32'(sb_q[d].size()), 32'h0);
      end
      if (rst_s[d]) begin
        sb_q[d].delete();
        last_rd[d] = 32'h0;
        armed[d]   = 1'b1;
      end else if (armed[d] && idle && req_s[d]) begin
        t.due   = cyc + lat_of(d) + 1;
        t.we    = we_s[d];
        t.mask  = mask_s[d];
        t.word  = (addr_s[d] >> 2) % DEPTH;
`ifdef DMEM_RANGE_ERR_EN
        t.oor   = (addr_s[d] >> (AW + 2)) != 0;
`else
        t.oor   = 1'b0;
`endif
        t.wdata = wdata_s[d];
        sb_q[d].push_back(t);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int d, input bit rq, input bit we, input logic [3:0] m,
                       input logic [31:0] a, input logic [31:0] w);
    req_s[d] = rq; we_s[d] = we; mask_s[d] = m; addr_s[d] = a; wdata_s[d] = w;
  endtask

  task automatic scramble(input int d, input bit rq);
    drive(d, rq, 1'($urandom), 4'($urandom), $urandom, $urandom);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
    if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_F000);
    return a;
  endfunction

  // One transaction with request dropped after accept; returns in IDLE.
  task automatic single(input int d, input bit we, input logic [3:0] m,
                        input logic [31:0] a, input logic [31:0] w);
    drive(d, 1'b1, we, m, a, w);
    @(posedge clk); #1;
    repeat (lat_of(d) + 1) begin
      scramble(d, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  // Request held high across n back-to-back transactions.
  task automatic burst(input int d, input int n);
    for (int k = 0; k < n; k++) begin
      drive(d, 1'b1, 1'($urandom), 4'($urandom), rand_addr(), $urandom);
      @(posedge clk); #1;
      repeat (lat_of(d) + 1) begin
        scramble(d, 1'b1);
        @(posedge clk); #1;
      end
    end
    req_s[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < N; d++) begin
      rst_s[d] = 1'b1;
      drive(d, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      last_rd[d] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < N; d++) rst_s[d] = 1'b0;

    // Known contents for the words used below.
    for (int d = 0; d < N; d++)
      for (int w = 0; w < 16; w++) single(d, 1'b1, 4'hF, 32'(w * 4), $urandom);

    // LATENCY=1 directed cases.
    single(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    single(0, 1'b0, 4'hF, 32'h10, 32'h0);
    single(0, 1'b1, 4'h1, 32'h10, 32'h000000AA);
    single(0, 1'b0, 4'h3, 32'h10, 32'h0);
    single(0, 1'b1, 4'h0, 32'h14, 32'hFFFFFFFF);
    single(0, 1'b0, 4'hF, 32'h14, 32'h0);
    drive(0, 1'b1, 1'b1, 4'hF, 32'h20, 32'h12345678);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    rst_s[0] = 1'b1;
    @(posedge clk); #1;
    rst_s[0] = 1'b0;
    single(0, 1'b0, 4'hF, 32'h20, 32'h0);
    single(0, 1'b0, 4'hF, 32'h1004, 32'h0);

    // LATENCY=0: request held for three back-to-back transactions.
    burst(1, 3);
    single(1, 1'b0, 4'hF, 32'h10, 32'h0);

    // Random mix of single and held-request traffic on both instances.
    for (int k = 0; k < 40; k++) begin
      for (int d = 0; d < N; d++) begin
        if ($urandom_range(0, 2) == 0) burst(d, int'($urandom_range(2, 4)));
        else single(d, 1'($urandom), 4'($urandom), rand_addr(), $urandom);
      end
    end

    repeat (4) @(posedge clk);
    #1 end_chk = 1'b1;
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
